// File: rtl/irrigation_pump_ctrl_pkg.sv
// Shared state codes and output widths for the irrigation pump controller.
package irrigation_pump_ctrl_pkg;

    localparam int ESTADO_W = 2;
    localparam int CICLOS_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        IDLE  = 2'd0,
        RIEGO = 2'd1,
        PAUSA = 2'd2,
        FALLA = 2'd3
    } pumpStateT;

endpackage

// File: rtl/irrigation_pump_ctrl_seg_timer.sv
// Prescaler plus tick counter. The tick fires on the last prescaler cycle;
// clear restarts both counters so a timed state begins on a clean boundary.
module irrigation_pump_ctrl_seg_timer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_TICKS = 30,
    parameter int CNT_W     = $clog2(MAX_TICKS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam int PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0] presc;

    assign tick = (presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc <= '0;
            count <= '0;
        end else if (tick) begin
            presc <= '0;
            count <= count + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/irrigation_pump_ctrl.sv
// Pump controller: timed watering pulses with soak pauses, gated by soil
// dryness, with a dry-run lockout released only once the tank is refilled.
module irrigation_pump_ctrl
    import irrigation_pump_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int RIEGO_S    = 10,
    parameter int PAUSA_S    = 30,
    parameter int MAX_CICLOS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MODbomba,
    input  logic                lowLevel,
    input  logic                highLevel,
    input  logic                soilDry,
    input  logic                startManual,
    output logic                activarBomba,
    output logic [ESTADO_W-1:0] estado,
    output logic                fallaSeco,
    output logic [CICLOS_W-1:0] ciclos
);

    localparam int MAX_TICKS = (RIEGO_S > PAUSA_S) ? RIEGO_S : PAUSA_S;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    pumpStateT           state, nextState;
    logic [CICLOS_W-1:0] nextCiclos;
    logic                lowMeta, lowSync;
    logic                highMeta, highSync;
    logic                soilMeta, soilSync;
    logic                tick;
    logic [CNT_W-1:0]    count;
    logic                riegoDone, pausaDone, req;

    always_ff @(posedge clk) begin
        if (reset) begin
            lowMeta  <= 1'b0;
            lowSync  <= 1'b0;
            highMeta <= 1'b0;
            highSync <= 1'b0;
            soilMeta <= 1'b0;
            soilSync <= 1'b0;
        end else begin
            lowMeta  <= lowLevel;
            lowSync  <= lowMeta;
            highMeta <= highLevel;
            highSync <= highMeta;
            soilMeta <= soilDry;
            soilSync <= soilMeta;
        end
    end

    irrigation_pump_ctrl_seg_timer #(
        .TICK_DIV (TICK_DIV),
        .MAX_TICKS(MAX_TICKS),
        .CNT_W    (CNT_W)
    ) uTimer (
        .clk  (clk),
        .reset(reset),
        .clear(nextState != state),
        .tick (tick),
        .count(count)
    );

    assign riegoDone = tick && (count == CNT_W'(RIEGO_S - 1));
    assign pausaDone = tick && (count == CNT_W'(PAUSA_S - 1));
    assign req       = soilSync | startManual;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ciclos <= '0;
        end else begin
            state  <= nextState;
            ciclos <= nextCiclos;
        end
    end

    // ciclos shows the final count for one IDLE cycle after a completed
    // pulse; every other way into IDLE clears it immediately.
    always_comb begin
        nextState  = state;
        nextCiclos = ciclos;
        case (state)
            IDLE: begin
                nextCiclos = '0;
                if (req && MODbomba && lowSync) nextState = RIEGO;
            end
            RIEGO: begin
                if (!lowSync) begin
                    nextState = FALLA;
                end else if (!MODbomba) begin
                    nextState  = IDLE;
                    nextCiclos = '0;
                end else if (riegoDone) begin
                    nextCiclos = ciclos + 1'b1;
                    if (nextCiclos == CICLOS_W'(MAX_CICLOS) || !soilSync)
                        nextState = IDLE;
                    else
                        nextState = PAUSA;
                end
            end
            PAUSA: begin
                if (!MODbomba) begin
                    nextState  = IDLE;
                    nextCiclos = '0;
                end else if (pausaDone) begin
                    if (soilSync && lowSync) begin
                        nextState = RIEGO;
                    end else begin
                        nextState  = IDLE;
                        nextCiclos = '0;
                    end
                end
            end
            FALLA: begin
                // highLevel without lowLevel is an inconsistent sensor pair; stay locked.
                if (highSync && lowSync) begin
                    nextState  = IDLE;
                    nextCiclos = '0;
                end
            end
            default: begin
                nextState  = IDLE;
                nextCiclos = '0;
            end
        endcase
    end

    assign activarBomba = (state == RIEGO);
    assign fallaSeco    = (state == FALLA);
    assign estado       = state;

endmodule

// File: tb/tb_irrigation_pump_ctrl.sv
// Directed bench for irrigation_pump_ctrl with TICK_DIV=4, RIEGO_S=3,
// PAUSA_S=2, MAX_CICLOS=2: a pulse lasts 12 cycles, a pause 8.
module tb_irrigation_pump_ctrl;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       MODbomba, lowLevel, highLevel, soilDry, startManual;
    logic       activarBomba, fallaSeco;
    logic [1:0] estado;
    logic [3:0] ciclos;

    logic [W-1:0] exp_q[$];
    int nChecks = 0;
    int nPass   = 0;
    int n;

    irrigation_pump_ctrl #(
        .TICK_DIV  (4),
        .RIEGO_S   (3),
        .PAUSA_S   (2),
        .MAX_CICLOS(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MODbomba    (MODbomba),
        .lowLevel    (lowLevel),
        .highLevel   (highLevel),
        .soilDry     (soilDry),
        .startManual (startManual),
        .activarBomba(activarBomba),
        .estado      (estado),
        .fallaSeco   (fallaSeco),
        .ciclos      (ciclos)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic stepClk(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs === expv) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    endtask

    task automatic checkOuts(input string tag, input logic [1:0] eEst, input logic eAct,
                             input logic eFalla, input logic [3:0] eCic);
        checkVal({tag, ".estado"}, estado, eEst);
        checkVal({tag, ".activarBomba"}, activarBomba, eAct);
        checkVal({tag, ".fallaSeco"}, fallaSeco, eFalla);
        checkVal({tag, ".ciclos"}, ciclos, eCic);
    endtask

    // Cycles until estado==code, bounded by maxC.
    task automatic waitState(input logic [1:0] code, input int maxC, output int cnt);
        cnt = 0;
        while (estado !== code && cnt < maxC) begin
            stepClk();
            cnt++;
        end
    endtask

    // Length of the current stay in estado==code; returns in the next state's first cycle.
    task automatic runLen(input logic [1:0] code, input int maxC, output int cnt);
        cnt = 0;
        while (estado === code && cnt < maxC) begin
            cnt++;
            stepClk();
        end
    endtask

    task automatic checkRun(input string tag, input logic [1:0] code);
        int len;
        logic [W-1:0] expLen;
        runLen(code, 40, len);
        expLen = exp_q.pop_front();
        checkVal(tag, len, expLen);
    endtask

    initial begin
        reset = 1'b1; MODbomba = 1'b0; lowLevel = 1'b0; highLevel = 1'b0;
        soilDry = 1'b0; startManual = 1'b0;
        stepClk(2);
        checkOuts("reset", 2'd0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        stepClk();
        checkOuts("idle_after_reset", 2'd0, 1'b0, 1'b0, 4'd0);

        // Basic pulse train: 12 on, 8 off, 12 on, then IDLE showing 2 then 0.
        MODbomba = 1'b1; lowLevel = 1'b1; soilDry = 1'b1;
        waitState(2'd1, 20, n);
        checkVal("train.start_latency", n, 3);
        checkVal("train.pump_on", activarBomba, 1'b1);
        exp_q.push_back(12); exp_q.push_back(8); exp_q.push_back(12);
        checkRun("train.riego1_len", 2'd1);
        checkOuts("train.pausa", 2'd2, 1'b0, 1'b0, 4'd1);
        checkRun("train.pausa_len", 2'd2);
        checkVal("train.riego2_estado", estado, 2'd1);
        soilDry = 1'b0;
        checkRun("train.riego2_len", 2'd1);
        checkOuts("train.done", 2'd0, 1'b0, 1'b0, 4'd2);
        stepClk();
        checkOuts("train.cleared", 2'd0, 1'b0, 1'b0, 4'd0);

        // Early satisfaction: pulse completes, then IDLE without a pause.
        soilDry = 1'b1;
        waitState(2'd1, 20, n);
        checkVal("early.start_latency", n, 3);
        soilDry = 1'b0;
        exp_q.push_back(12);
        checkRun("early.riego_len", 2'd1);
        checkOuts("early.idle", 2'd0, 1'b0, 1'b0, 4'd1);
        stepClk();
        checkVal("early.ciclos_cleared", ciclos, 4'd0);

        // Dry-run lockout with hysteresis.
        soilDry = 1'b1;
        waitState(2'd1, 20, n);
        stepClk(4);
        lowLevel = 1'b0;
        stepClk(2);
        checkVal("dry.still_riego", estado, 2'd1);
        stepClk();
        checkOuts("dry.falla", 2'd3, 1'b0, 1'b1, 4'd0);
        MODbomba = 1'b0; startManual = 1'b1;
        stepClk();
        startManual = 1'b0; MODbomba = 1'b1;
        stepClk(2);
        checkOuts("dry.ignore_inputs", 2'd3, 1'b0, 1'b1, 4'd0);
        highLevel = 1'b1;
        stepClk(5);
        checkVal("dry.high_without_low", estado, 2'd3);
        lowLevel = 1'b1; soilDry = 1'b0;
        stepClk(2);
        checkVal("dry.sync_hold", estado, 2'd3);
        stepClk();
        checkOuts("dry.released", 2'd0, 1'b0, 1'b0, 4'd0);
        stepClk(2);
        checkVal("dry.stays_idle", estado, 2'd0);

        // Manual request on an empty tank.
        lowLevel = 1'b0; highLevel = 1'b0;
        stepClk(3);
        startManual = 1'b1;
        stepClk();
        startManual = 1'b0;
        checkOuts("manual_empty", 2'd0, 1'b0, 1'b0, 4'd0);
        stepClk(3);
        checkOuts("manual_empty.later", 2'd0, 1'b0, 1'b0, 4'd0);

        // Manual request on a full tank, soil wet: one pulse then IDLE.
        lowLevel = 1'b1;
        stepClk(3);
        startManual = 1'b1;
        stepClk();
        startManual = 1'b0;
        checkVal("manual_ok.riego", estado, 2'd1);
        exp_q.push_back(12);
        checkRun("manual_ok.len", 2'd1);
        checkOuts("manual_ok.idle", 2'd0, 1'b0, 1'b0, 4'd1);

        // Mode off mid-pause, then re-enable.
        soilDry = 1'b1;
        waitState(2'd1, 20, n);
        exp_q.push_back(12);
        checkRun("mode.riego_len", 2'd1);
        checkVal("mode.pausa", estado, 2'd2);
        stepClk(3);
        MODbomba = 1'b0;
        stepClk();
        checkOuts("mode.off_idle", 2'd0, 1'b0, 1'b0, 4'd0);
        stepClk(2);
        checkVal("mode.off_stays", estado, 2'd0);
        MODbomba = 1'b1;
        stepClk();
        checkVal("mode.reenable_riego", estado, 2'd1);
        exp_q.push_back(12);
        checkRun("mode.reenable_len", 2'd1);
        checkVal("mode.pausa2", estado, 2'd2);
        soilDry = 1'b0;
        waitState(2'd0, 20, n);
        checkVal("mode.pause_to_idle_ciclos", ciclos, 4'd0);

        // Reset mid-pulse.
        soilDry = 1'b1;
        waitState(2'd1, 20, n);
        stepClk(2);
        reset = 1'b1;
        stepClk();
        checkOuts("reset_mid", 2'd0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        waitState(2'd1, 20, n);
        checkVal("reset_mid.restart_latency", n, 3);

        // Expiry and lowLevel loss in the same cycle: fault wins, ciclos held.
        exp_q.push_back(12); exp_q.push_back(8);
        checkRun("coinc.riego1_len", 2'd1);
        checkRun("coinc.pausa_len", 2'd2);
        stepClk(9);
        lowLevel = 1'b0;
        stepClk();
        checkVal("coinc.cycle11", estado, 2'd1);
        stepClk();
        checkVal("coinc.cycle12", estado, 2'd1);
        stepClk();
        checkOuts("coinc.falla", 2'd3, 1'b0, 1'b1, 4'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
